// File: rtl/tf0_in_buffer_pkg.sv
// Shared types and sizing helpers for the TestFunction0 input buffer.
package tf0_buffer_pkg;

  localparam int TF0_DATA_W = 32;

  typedef logic signed [31:0] tf0_word_t;

  // Occupancy needs one extra bit so that "full" (level == DEPTH) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tf0_in_buffer_if.sv
// Source-side valid/ready and consumer-side notify/sync signals of the input buffer.
interface tf0_in_buffer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_notify;
  logic              out_sync;

  modport slave (
    input  in_data, in_valid, out_sync,
    output in_ready, out_data, out_notify
  );

  modport master (
    output in_data, in_valid, out_sync,
    input  in_ready, out_data, out_notify
  );
endinterface

// File: rtl/tf0_fifo_mem.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read.
module tf0_fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/tf0_in_buffer.sv
// Producer-side FIFO for b_in: valid/ready in, blocking notify/sync out,
// with transfer counter and sticky overflow status.
module tf0_in_buffer
  import tf0_buffer_pkg::*;
#(
  parameter int DATA_W = TF0_DATA_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 32,
  localparam int LEVEL_W = level_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  tf0_in_buffer_if.slave     bus,
  output logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   xfer_count,
  output logic               overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Handshake flags come from the registered level only, so no in_* to out_* path exists.
  assign bus.in_ready   = (level != LEVEL_W'(DEPTH));
  assign bus.out_notify = (level != '0);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_notify && bus.out_sync;

  tf0_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr),
    .wdata (bus.in_data),
    .raddr (rd_ptr),
    .rdata (bus.out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      xfer_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        xfer_count <= xfer_count + CNT_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
      if (bus.in_valid && !bus.in_ready) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tf0_in_buffer.sv
// Self-checking bench for tf0_in_buffer: directed vector table, a full-with-pop
// sequence, and randomized back-pressure against a queue-based reference model.
module tb_tf0_in_buffer;
  import tf0_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  level;
  logic [31:0] xfer_count;
  logic        overflow;

  tf0_in_buffer_if #(.DATA_W(32)) bus ();

  tf0_in_buffer #(
    .DATA_W (32),
    .DEPTH  (DEPTH),
    .CNT_W  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .level      (level),
    .xfer_count (xfer_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        valid;
    logic [31:0] data;
    logic        sync;
    logic        e_ready;
    logic        e_notify;
    logic [31:0] e_data;
    int          e_level;
    int          e_xfer;
    logic        e_ov;
  } vec_t;

  vec_t vecs[20];

  task automatic drive(input logic r, input logic v, input logic [31:0] d, input logic s);
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.out_sync = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tf0_word_t neg7;
    int q[$];
    int nxt, rx, cyc;
    bit ovm, v, s, pu, po;

    neg7 = -7;
    drive(1'b1, 1'b0, 32'd0, 1'b0);

    //          rst valid data          sync  ready notify data         lvl xfer ov
    vecs[0]  = '{1, 1, 32'd99,           0,    1,   0,  32'd0,          0,  0,  0};
    vecs[1]  = '{1, 1, 32'd99,           0,    1,   0,  32'd0,          0,  0,  0};
    vecs[2]  = '{0, 1, 32'h0000_002A,    1,    1,   1,  32'd42,         1,  0,  0};
    vecs[3]  = '{0, 0, 32'd0,            1,    1,   0,  32'd0,          0,  1,  0};
    vecs[4]  = '{0, 1, 32'd1,            0,    1,   1,  32'd1,          1,  1,  0};
    vecs[5]  = '{0, 1, 32'd2,            0,    1,   1,  32'd1,          2,  1,  0};
    vecs[6]  = '{0, 1, 32'd3,            0,    1,   1,  32'd1,          3,  1,  0};
    vecs[7]  = '{0, 1, 32'd4,            0,    0,   1,  32'd1,          4,  1,  0};
    vecs[8]  = '{0, 1, 32'd5,            0,    0,   1,  32'd1,          4,  1,  1};
    vecs[9]  = '{0, 0, 32'd0,            1,    1,   1,  32'd2,          3,  2,  1};
    vecs[10] = '{0, 0, 32'd0,            1,    1,   1,  32'd3,          2,  3,  1};
    vecs[11] = '{0, 1, 32'd6,            1,    1,   1,  32'd4,          2,  4,  1};
    vecs[12] = '{0, 1, 32'd7,            1,    1,   1,  32'd6,          2,  5,  1};
    vecs[13] = '{0, 1, 32'd8,            1,    1,   1,  32'd7,          2,  6,  1};
    vecs[14] = '{0, 0, 32'd0,            1,    1,   1,  32'd8,          1,  7,  1};
    vecs[15] = '{0, 1, 32'd9,            0,    1,   1,  32'd8,          2,  7,  1};
    vecs[16] = '{0, 1, 32'd10,           0,    1,   1,  32'd8,          3,  7,  1};
    vecs[17] = '{1, 1, 32'd11,           1,    1,   0,  32'd0,          0,  0,  0};
    vecs[18] = '{0, 1, neg7,             0,    1,   1,  32'hFFFF_FFF9,  1,  0,  0};
    vecs[19] = '{0, 0, 32'd0,            1,    1,   0,  32'd0,          0,  1,  0};

    #2;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].sync);
      step();
      chk($sformatf("v%0d_ready", i),  32'(bus.in_ready),   32'(vecs[i].e_ready));
      chk($sformatf("v%0d_notify", i), 32'(bus.out_notify), 32'(vecs[i].e_notify));
      chk($sformatf("v%0d_level", i),  32'(level),          vecs[i].e_level);
      chk($sformatf("v%0d_xfer", i),   xfer_count,          vecs[i].e_xfer);
      chk($sformatf("v%0d_ovf", i),    32'(overflow),       32'(vecs[i].e_ov));
      if (vecs[i].e_notify)
        chk($sformatf("v%0d_data", i), bus.out_data, vecs[i].e_data);
    end

    // Full FIFO with a pop on the same edge: the offered word must be dropped.
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 32'(10 + i), 1'b0);
      step();
    end
    chk("full_level", 32'(level), 32'd4);
    drive(1'b0, 1'b1, 32'd99, 1'b1);
    step();
    chk("fullpop_level", 32'(level), 32'd3);
    chk("fullpop_ready", 32'(bus.in_ready), 32'd1);
    chk("fullpop_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("fullpop_data%0d", i), bus.out_data, 32'(10 + i));
      drive(1'b0, 1'b0, 32'd0, 1'b1);
      step();
    end
    chk("fullpop_empty", 32'(bus.out_notify), 32'd0);
    chk("fullpop_xfer", xfer_count, 32'd4);

    // Randomized producer/consumer pressure against a queue model.
    drive(1'b1, 1'b0, 32'd0, 1'b0);
    step();
    q.delete();
    nxt = 0; rx = 0; cyc = 0; ovm = 0;
    while (rx < 100 && cyc < 3000) begin
      v = (nxt < 100) && ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 1) == 1);
      drive(1'b0, v, 32'(nxt), s);
      chk("rnd_ready",  32'(bus.in_ready),   32'(q.size() < DEPTH));
      chk("rnd_notify", 32'(bus.out_notify), 32'(q.size() > 0));
      chk("rnd_level",  32'(level),          32'(q.size()));
      chk("rnd_xfer",   xfer_count,          32'(rx));
      if (q.size() > 0)
        chk("rnd_data", bus.out_data, 32'(q[0]));
      pu = v && (q.size() < DEPTH);
      po = s && (q.size() > 0);
      if (v && q.size() == DEPTH) ovm = 1;
      if (po) begin
        chk("rnd_order", bus.out_data, 32'(rx));
        void'(q.pop_front());
        rx++;
      end
      if (pu) begin
        q.push_back(nxt);
        nxt++;
      end
      step();
      cyc++;
    end
    chk("rnd_received", 32'(rx), 32'd100);
    chk("rnd_final_xfer", xfer_count, 32'd100);
    chk("rnd_ovf", 32'(overflow), 32'(ovm));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
